// File: rtl/stream_arbiter_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stream_arbiter_pkg;

    // Arbiter FSM: IDLE picks a new winner each beat, LOCK holds one port for a burst
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    // Grant index width; a 2-port arbiter still needs one bit
    function automatic int gw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_arbiter_pick.sv
// Round-robin winner search starting at ptr, wrapping at NUM_PORTS-1.
// Latency: purely combinational.
// Backpressure: none; caller gates the grant with output-slot availability.
module stream_arbiter_pick #(
    parameter int NUM_PORTS = 4,
    parameter int GW        = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [GW-1:0]        ptr,
    output logic [GW-1:0]        winner,
    output logic                 any
);

    // First requester found in the order ptr, ptr+1, ... (mod NUM_PORTS)
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        any    = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = GW'(idx);
            end
        end
    end

endmodule

// File: rtl/stream_arbiter.sv
// Round-robin burst arbiter: NUM_PORTS valid/ready streams onto one tagged output stream.
// Latency: 1 cycle from input acceptance to oValid_BM; 1 beat/cycle sustained.
// Backpressure: one-entry output register; upstream ready only when that slot is empty or draining.
module stream_arbiter
    import stream_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int WIDTH     = 8
) (
    input  logic                          iCLK,
    input  logic                          iRST,
    input  logic [NUM_PORTS-1:0]          iValid_AM,
    output logic [NUM_PORTS-1:0]          oReady_AM,
    input  logic [NUM_PORTS*WIDTH-1:0]    iData_AM,
    input  logic [NUM_PORTS-1:0]          iLast_AM,
    output logic                          oValid_BM,
    input  logic                          iReady_BM,
    output logic [WIDTH-1:0]              oData_BM,
    output logic                          oLast_BM,
    output logic [gw_of(NUM_PORTS)-1:0]   oGrant_BM
);

    localparam int GW = gw_of(NUM_PORTS);

    state_e          state_q, state_d;
    logic [GW-1:0]   ptr_q, ptr_d;
    logic [GW-1:0]   gnt_q, gnt_d;
    logic            valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic            last_q, last_d;
    logic [GW-1:0]   grant_q, grant_d;

    logic [GW-1:0]   pick_winner;
    logic            pick_any;
    logic            slot_free;
    logic [GW-1:0]   sel;
    logic            sel_vld;
    logic [WIDTH-1:0] sel_data;
    logic            sel_last;
    logic            in_xfer;

    stream_arbiter_pick #(
        .NUM_PORTS (NUM_PORTS),
        .GW        (GW)
    ) u_pick (
        .req    (iValid_AM),
        .ptr    (ptr_q),
        .winner (pick_winner),
        .any    (pick_any)
    );

    // Output slot can take a beat when empty or when its current beat leaves this cycle
    assign slot_free = ~valid_q | iReady_BM;

    // Select the serviced port and drive its ready; data never feeds ready
    always_comb begin
        sel       = (state_q == ST_LOCK) ? gnt_q : pick_winner;
        sel_vld   = (state_q == ST_LOCK) ? iValid_AM[gnt_q] : pick_any;
        sel_data  = '0;
        sel_last  = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (GW'(p) == sel) begin
                sel_data = iData_AM[p*WIDTH +: WIDTH];
                sel_last = iLast_AM[p];
            end
        end
        oReady_AM = '0;
        if (iRST && ((state_q == ST_LOCK) || pick_any)) begin
            oReady_AM[sel] = slot_free;
        end
        in_xfer = iRST & sel_vld & slot_free;
    end

    // Next-state: burst lock/unlock, pointer advance past the finishing port, output register load
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        if (in_xfer) begin
            if (sel_last) begin
                state_d = ST_IDLE;
                ptr_d   = (sel == GW'(NUM_PORTS - 1)) ? '0 : sel + GW'(1);
            end else begin
                state_d = ST_LOCK;
                gnt_d   = sel;
            end
        end
        valid_d = in_xfer | (valid_q & ~iReady_BM);
        data_d  = in_xfer ? sel_data : data_q;
        last_d  = in_xfer ? sel_last : last_q;
        grant_d = in_xfer ? sel : grant_q;
    end

    // State and output register; reset drops any burst in flight and the held beat
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            grant_q <= grant_d;
        end
    end

    assign oValid_BM = valid_q;
    assign oData_BM  = data_q;
    assign oLast_BM  = last_q;
    assign oGrant_BM = grant_q;

endmodule
